ifetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC register and drives the instruction-memory request. It selects the next PC from the redirects supplied by decode (sequential, branch, jump, jump-register). It also owns the IF/ID pipeline latch that feeds decode (ifetch_t contents plus a valid bit), and handles stall, flush, redirect-during-miss and halt.

---
 rtl/ifetch_stage_pkg.sv | 22 ++
 rtl/ifid_latch.sv | 29 ++
 rtl/ifetch_stage.sv | 128 ++++++++++++
 tb/tb_ifetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_stage_pkg.sv
// Shared pipeline types for the fetch stage: machine word, IF/ID payload and the
// next-PC select encoding driven by decode.
package ifetch_stage_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_J   = 2'd2,
    PC_JR  = 2'd3
  } pcsel_t;

  typedef struct packed {
    word_t instr;
    word_t pc;        // PC+4 of the instruction
    word_t imemAddr;  // address it was fetched from
  } ifetch_t;

  localparam word_t WORD_BYTES = 32'd4;

endpackage

// File: rtl/ifid_latch.sv
// Generic pipeline stage register: ifetch_t payload plus valid, with load, flush and
// bubble controls. A bubble clears valid and the instruction word only.
module ifid_latch
  import ifetch_stage_pkg::*;
(
  input  logic    CLK,
  input  logic    nRST,
  input  logic    load,
  input  logic    flush,
  input  logic    bubble,
  input  ifetch_t din,
  output ifetch_t dout,
  output logic    valid
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (flush || bubble) begin
      dout.instr <= '0;
      valid      <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, miss-safe redirect
// handling (DRAIN) and terminal halt, feeding the IF/ID latch.
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic   CLK,
  input  logic   nRST,
  input  logic   ihit,
  input  word_t  imemload,
  output logic   imemREN,
  output word_t  imemaddr,
  input  logic   stall,
  input  logic   flush,
  input  pcsel_t pc_sel,
  input  word_t  brAddr,
  input  word_t  jAddr,
  input  word_t  jrAddr,
  input  logic   halt,
  output word_t  ifid_instr,
  output word_t  ifid_pc,
  output word_t  ifid_imemAddr,
  output logic   ifid_valid
);

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HALTED
  } fetch_state_t;

  fetch_state_t state;
  word_t        pc;
  word_t        pend_addr;
  word_t        pc_next4;
  word_t        target;
  logic         redirect;
  logic         latch_load;
  logic         latch_bubble;
  ifetch_t      latch_din;
  ifetch_t      latch_dout;

  assign pc_next4 = pc + WORD_BYTES;
  assign redirect = (pc_sel != PC_SEQ);
  assign imemaddr = pc;
  assign imemREN  = (state != HALTED);

  always_comb begin
    target = jrAddr;
    case (pc_sel)
      PC_BR:   target = brAddr;
      PC_J:    target = jAddr;
      default: target = jrAddr;
    endcase
  end

  // Only a clean hit in FETCH with no halt/redirect/stall loads; stall simply holds.
  always_comb begin
    latch_load   = 1'b0;
    latch_bubble = 1'b0;
    if (state == FETCH) begin
      if (halt || redirect)  latch_bubble = 1'b1;
      else if (stall)        latch_bubble = 1'b0;
      else if (ihit)         latch_load   = 1'b1;
      else                   latch_bubble = 1'b1;
    end else begin
      latch_bubble = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= FETCH;
      pc        <= PC_INIT;
      pend_addr <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (halt) begin
            state <= HALTED;
          end else if (redirect) begin
            // On a miss the request address must stay put; park the target.
            if (ihit) begin
              pc <= target;
            end else begin
              pend_addr <= target;
              state     <= DRAIN;
            end
          end else if (!stall && ihit) begin
            pc <= pc_next4;
          end
        end
        DRAIN: begin
          if (halt) begin
            state <= HALTED;
          end else begin
            if (redirect) pend_addr <= target;
            if (ihit) begin
              pc    <= redirect ? target : pend_addr;
              state <= FETCH;
            end
          end
        end
        HALTED: ;
        default: state <= FETCH;
      endcase
    end
  end

  assign latch_din = '{instr: imemload, pc: pc_next4, imemAddr: pc};

  ifid_latch u_ifid (
    .CLK    (CLK),
    .nRST   (nRST),
    .load   (latch_load),
    .flush  (flush),
    .bubble (latch_bubble),
    .din    (latch_din),
    .dout   (latch_dout),
    .valid  (ifid_valid)
  );

  assign ifid_instr    = latch_dout.instr;
  assign ifid_pc       = latch_dout.pc;
  assign ifid_imemAddr = latch_dout.imemAddr;

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed scenarios plus a randomized run checked against a
// behavioural model of fetch (mode, pc, pending target, IF/ID contents).
module tb_ifetch_stage;
  import ifetch_stage_pkg::*;

  localparam word_t PC_INIT = 32'h0000_0000;

  logic   CLK = 1'b0;
  logic   nRST = 1'b0;
  logic   ihit = 1'b0, stall = 1'b0, flush = 1'b0, halt = 1'b0;
  word_t  imemload = '0, brAddr = '0, jAddr = '0, jrAddr = '0;
  pcsel_t pc_sel = PC_SEQ;
  logic   imemREN, ifid_valid;
  word_t  imemaddr, ifid_instr, ifid_pc, ifid_imemAddr;

  int total = 0;
  int bad   = 0;

  // model: mode 0 = fetching, 1 = waiting out a miss before redirect, 2 = halted
  int    m_mode;
  word_t m_pc, m_pend, m_instr, m_ipc, m_iaddr;
  logic  m_valid;

  always #5 CLK = ~CLK;

  ifetch_stage #(.PC_INIT(PC_INIT)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
    .imemaddr(imemaddr), .stall(stall), .flush(flush), .pc_sel(pc_sel),
    .brAddr(brAddr), .jAddr(jAddr), .jrAddr(jrAddr), .halt(halt),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_imemAddr(ifid_imemAddr),
    .ifid_valid(ifid_valid)
  );

  task automatic model_reset();
    m_mode = 0; m_pc = PC_INIT; m_pend = '0;
    m_instr = '0; m_ipc = '0; m_iaddr = '0; m_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    ihit = 0; stall = 0; flush = 0; halt = 0; pc_sel = PC_SEQ;
  endtask

  // Advance one clock with whatever inputs are driven; update the model from the rules.
  task automatic tick();
    word_t tgt, n_pc, n_pend, n_instr, n_ipc, n_iaddr;
    logic  n_valid, bub;
    int    n_mode;
    tgt = (pc_sel == PC_BR) ? brAddr : (pc_sel == PC_J) ? jAddr : jrAddr;
    n_mode = m_mode; n_pc = m_pc; n_pend = m_pend;
    n_instr = m_instr; n_ipc = m_ipc; n_iaddr = m_iaddr; n_valid = m_valid;
    bub = 1'b0;
    if (m_mode == 2) begin
      bub = 1'b1;
    end else if (halt) begin
      n_mode = 2; bub = 1'b1;
    end else if (m_mode == 1) begin
      bub = 1'b1;
      if (pc_sel != PC_SEQ) n_pend = tgt;
      if (ihit) begin n_pc = n_pend; n_mode = 0; end
    end else if (pc_sel != PC_SEQ) begin
      bub = 1'b1;
      if (ihit) n_pc = tgt;
      else begin n_pend = tgt; n_mode = 1; end
    end else if (stall) begin
      bub = 1'b0;
    end else if (ihit) begin
      n_instr = imemload; n_ipc = m_pc + 32'd4; n_iaddr = m_pc; n_valid = 1'b1;
      n_pc = m_pc + 32'd4;
    end else begin
      bub = 1'b1;
    end
    if (bub || flush) begin n_valid = 1'b0; n_instr = '0; end
    @(posedge CLK); #1;
    m_mode = n_mode; m_pc = n_pc; m_pend = n_pend;
    m_instr = n_instr; m_ipc = n_ipc; m_iaddr = n_iaddr; m_valid = n_valid;
  endtask

  task automatic reset_dut();
    nRST = 0; #2;
    model_reset();
    nRST = 1;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      ihit = 1; imemload = $urandom; tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 0; model_reset();
    #12;
    total++; if (imemaddr !== PC_INIT || imemREN !== 1'b1) begin bad++;
      $display("FAIL reset_addr got addr=%h ren=%b exp addr=%h ren=1", imemaddr, imemREN, PC_INIT); end
    total++; if ({ifid_instr, ifid_pc, ifid_imemAddr, ifid_valid} !== '0) begin bad++;
      $display("FAIL reset_ifid got %h %h %h %b exp all zero", ifid_instr, ifid_pc, ifid_imemAddr, ifid_valid); end
    @(negedge CLK); nRST = 1;
  endtask

  task automatic test_sequential();
    word_t d;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      total++; if (imemaddr !== 32'(4 * i)) begin bad++;
        $display("FAIL seq_addr got=%h exp=%h", imemaddr, 32'(4 * i)); end
      d = $urandom; ihit = 1; imemload = d; tick();
      total++; if (ifid_valid !== 1'b1 || ifid_instr !== d || ifid_pc !== 32'(4 * i + 4) || ifid_imemAddr !== 32'(4 * i)) begin bad++;
        $display("FAIL seq_ifid got v=%b i=%h pc=%h a=%h exp v=1 i=%h pc=%h a=%h",
                 ifid_valid, ifid_instr, ifid_pc, ifid_imemAddr, d, 32'(4 * i + 4), 32'(4 * i)); end
    end
    idle_inputs();
  endtask

  task automatic test_miss();
    reset_dut(); hits(4);
    for (int i = 0; i < 3; i++) begin
      ihit = 0; tick();
      total++; if (imemaddr !== 32'h10 || ifid_valid !== 1'b0) begin bad++;
        $display("FAIL miss_hold got addr=%h v=%b exp addr=00000010 v=0", imemaddr, ifid_valid); end
    end
    ihit = 1; imemload = 32'h8C22_0004; tick(); idle_inputs();
    total++; if (ifid_instr !== 32'h8C22_0004 || ifid_pc !== 32'h14 || ifid_valid !== 1'b1) begin bad++;
      $display("FAIL miss_fill got i=%h pc=%h v=%b exp i=8c220004 pc=00000014 v=1", ifid_instr, ifid_pc, ifid_valid); end
  endtask

  task automatic test_stall();
    word_t prev, d;
    reset_dut(); hits(8);
    prev = ifid_instr;
    for (int i = 0; i < 2; i++) begin
      stall = 1; ihit = 1; imemload = $urandom; tick();
      total++; if (imemaddr !== 32'h20 || ifid_instr !== prev || ifid_pc !== 32'h20 || ifid_valid !== 1'b1) begin bad++;
        $display("FAIL stall_hold got addr=%h i=%h pc=%h v=%b exp addr=00000020 i=%h pc=00000020 v=1",
                 imemaddr, ifid_instr, ifid_pc, ifid_valid, prev); end
    end
    stall = 0; d = 32'hA5A5_0020; imemload = d; tick(); idle_inputs();
    total++; if (ifid_instr !== d || ifid_imemAddr !== 32'h20 || imemaddr !== 32'h24) begin bad++;
      $display("FAIL stall_release got i=%h a=%h pc=%h exp i=%h a=00000020 pc=00000024", ifid_instr, ifid_imemAddr, imemaddr, d); end
  endtask

  task automatic test_branch_drain();
    reset_dut(); hits(16);
    pc_sel = PC_BR; brAddr = 32'h100; jAddr = 32'h999; jrAddr = 32'h777; ihit = 0; tick();
    pc_sel = PC_SEQ; tick();
    total++; if (imemaddr !== 32'h40 || ifid_valid !== 1'b0 || imemREN !== 1'b1) begin bad++;
      $display("FAIL drain_hold got addr=%h v=%b ren=%b exp addr=00000040 v=0 ren=1", imemaddr, ifid_valid, imemREN); end
    ihit = 1; imemload = 32'hDEAD_0040; tick();
    total++; if (imemaddr !== 32'h100 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin bad++;
      $display("FAIL drain_done got addr=%h v=%b i=%h exp addr=00000100 v=0 i=0", imemaddr, ifid_valid, ifid_instr); end
    imemload = 32'h1234_0100; tick(); idle_inputs();
    total++; if (ifid_valid !== 1'b1 || ifid_imemAddr !== 32'h100 || ifid_instr !== 32'h1234_0100) begin bad++;
      $display("FAIL drain_target got v=%b a=%h i=%h exp v=1 a=00000100 i=12340100", ifid_valid, ifid_imemAddr, ifid_instr); end
  endtask

  task automatic test_jr_flush();
    reset_dut(); hits(2);
    pc_sel = PC_JR; jrAddr = 32'h200; brAddr = 32'h300; jAddr = 32'h400; ihit = 1; imemload = $urandom; tick();
    total++; if (imemaddr !== 32'h200 || ifid_valid !== 1'b0) begin bad++;
      $display("FAIL jr_hit got addr=%h v=%b exp addr=00000200 v=0", imemaddr, ifid_valid); end
    pc_sel = PC_SEQ; flush = 1; tick(); idle_inputs();
    total++; if (imemaddr !== 32'h204 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin bad++;
      $display("FAIL flush_hit got addr=%h v=%b i=%h exp addr=00000204 v=0 i=0", imemaddr, ifid_valid, ifid_instr); end
  endtask

  task automatic test_halt_reset();
    reset_dut(); hits(3);
    pc_sel = PC_J; jAddr = 32'h80; ihit = 0; tick();
    pc_sel = PC_SEQ; halt = 1; tick();
    total++; if (imemREN !== 1'b0 || ifid_valid !== 1'b0 || imemaddr !== 32'h0C) begin bad++;
      $display("FAIL halt_drain got ren=%b v=%b addr=%h exp ren=0 v=0 addr=0000000c", imemREN, ifid_valid, imemaddr); end
    halt = 0; ihit = 1; pc_sel = PC_BR; brAddr = 32'h500; tick();
    pc_sel = PC_SEQ; tick();
    total++; if (imemREN !== 1'b0 || imemaddr !== 32'h0C || ifid_valid !== 1'b0) begin bad++;
      $display("FAIL halt_sticky got ren=%b addr=%h v=%b exp ren=0 addr=0000000c v=0", imemREN, imemaddr, ifid_valid); end
    idle_inputs();
    #2; nRST = 0; #1;
    total++; if (imemaddr !== PC_INIT || imemREN !== 1'b1) begin bad++;
      $display("FAIL async_reset got addr=%h ren=%b exp addr=%h ren=1", imemaddr, imemREN, PC_INIT); end
    model_reset(); nRST = 1;
    ihit = 1; imemload = 32'hCAFE_0000; tick(); idle_inputs();
    total++; if (ifid_valid !== 1'b1 || ifid_imemAddr !== PC_INIT || ifid_instr !== 32'hCAFE_0000) begin bad++;
      $display("FAIL restart got v=%b a=%h i=%h exp v=1 a=%h i=cafe0000", ifid_valid, ifid_imemAddr, ifid_instr, PC_INIT); end
  endtask

  task automatic test_random();
    int r;
    reset_dut();
    for (int n = 0; n < 800; n++) begin
      if (m_mode == 2 && ($urandom % 6) == 0) reset_dut();
      ihit = ($urandom % 4) != 0;
      stall = ($urandom % 5) == 0;
      flush = ($urandom % 9) == 0;
      halt = ($urandom % 120) == 0;
      r = int'($urandom % 8);
      pc_sel = (r < 5) ? PC_SEQ : pcsel_t'(r - 4);
      imemload = $urandom; brAddr = $urandom; jAddr = $urandom; jrAddr = $urandom;
      tick();
      total++; if (imemaddr !== m_pc || imemREN !== (m_mode != 2)) begin bad++;
        $display("FAIL rnd_fetch cyc=%0d got addr=%h ren=%b exp addr=%h ren=%b", n, imemaddr, imemREN, m_pc, m_mode != 2); end
      total++; if (ifid_valid !== m_valid || ifid_instr !== m_instr ||
                   (m_valid && (ifid_pc !== m_ipc || ifid_imemAddr !== m_iaddr))) begin bad++;
        $display("FAIL rnd_ifid cyc=%0d got v=%b i=%h pc=%h a=%h exp v=%b i=%h pc=%h a=%h", n,
                 ifid_valid, ifid_instr, ifid_pc, ifid_imemAddr, m_valid, m_instr, m_ipc, m_iaddr); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_miss();
    test_stall();
    test_branch_drain();
    test_jr_flush();
    test_halt_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
